// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: interlocks, redirect flushes, operand forwarding and data-memory wait/timeout.
// Optional feature macro: PIPE_CTRL_FORWARD_EN (forwarding paths present; only load-use stalls).
module pipe_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_rs1_need,
    input  logic        id_rs2_need,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_we,
    input  logic        ex_is_load,
    input  logic [4:0]  mem_rd,
    input  logic        mem_reg_we,
    input  logic        ex_redirect,
    input  logic        dmem_req,
    input  logic        dmem_ack,
    output logic        pc_hold,
    output logic        ifid_hold,
    output logic        idex_bubble,
    output logic        ifid_flush,
    output logic        exmem_hold,
    output logic        memwb_bubble,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic        bus_err,
    output logic [15:0] stall_cnt
);

    typedef enum logic {RUN, MWAIT} state_t;

    localparam logic [7:0] LAST_WAIT = 8'(MEM_TIMEOUT - 1);

    state_t     state;
    logic [7:0] wait_cnt;
    logic       a_ex, a_mem, b_ex, b_mem;
    logic       load_use, stall_hazard;
    logic       mem_busy, redirect, stall;

    function automatic logic reg_match(input logic need, input logic [4:0] rs,
                                       input logic [4:0] rd, input logic we);
        return need && (rs != 5'd0) && we && (rs == rd);
    endfunction

    assign a_ex     = reg_match(id_rs1_need, id_rs1, ex_rd, ex_reg_we);
    assign a_mem    = reg_match(id_rs1_need, id_rs1, mem_rd, mem_reg_we);
    assign b_ex     = reg_match(id_rs2_need, id_rs2, ex_rd, ex_reg_we);
    assign b_mem    = reg_match(id_rs2_need, id_rs2, mem_rd, mem_reg_we);
    assign load_use = ex_is_load && (a_ex || b_ex);

`ifdef PIPE_CTRL_FORWARD_EN
    assign stall_hazard = load_use;
`else
    // load_use is already covered by the EX matches; kept so every input is consumed
    assign stall_hazard = a_ex || a_mem || b_ex || b_mem || load_use;
`endif

    assign mem_busy = (dmem_req && !dmem_ack) || (state == MWAIT);
    assign redirect = !mem_busy && ex_redirect;
    assign stall    = !mem_busy && !ex_redirect && stall_hazard;

    assign pc_hold      = mem_busy || stall;
    assign ifid_hold    = mem_busy || stall;
    assign idex_bubble  = redirect || stall;
    assign ifid_flush   = redirect;
    assign exmem_hold   = mem_busy;
    assign memwb_bubble = mem_busy;

    // An ack in the final wait cycle wins over the timeout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= 8'd0;
            bus_err  <= 1'b0;
        end else begin
            bus_err <= 1'b0;
            case (state)
                RUN: begin
                    if (dmem_req && !dmem_ack) begin
                        state    <= MWAIT;
                        wait_cnt <= 8'd0;
                    end
                end
                MWAIT: begin
                    if (dmem_ack) begin
                        state <= RUN;
                    end else if (wait_cnt == LAST_WAIT) begin
                        state   <= RUN;
                        bus_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= 16'd0;
        end else if (pc_hold && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

`ifdef PIPE_CTRL_FORWARD_EN
    // Select is captured with the ID/EX register: frozen while memory is busy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_a <= 2'b00;
            fwd_b <= 2'b00;
        end else if (!mem_busy) begin
            if (idex_bubble) begin
                fwd_a <= 2'b00;
                fwd_b <= 2'b00;
            end else begin
                fwd_a <= (a_ex && !ex_is_load) ? 2'b01 : (a_mem ? 2'b10 : 2'b00);
                fwd_b <= (b_ex && !ex_is_load) ? 2'b01 : (b_mem ? 2'b10 : 2'b00);
            end
        end
    end
`else
    assign fwd_a = 2'b00;
    assign fwd_b = 2'b00;
`endif

endmodule
